// File: rtl/runner_pkg.sv
// Shared definitions for the runner game: FSM state encoding and screen geometry.
package runner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  localparam int unsigned SCREEN_W    = 640;
  localparam int unsigned SCREEN_H    = 480;
  localparam int unsigned BLOCK_LINES = 16;

endpackage

// File: rtl/frame_tick_detect.sv
// Two-flop rising-edge detector on the frame update level; one-clk pulse out.
module frame_tick_detect (
  input  logic clk,
  input  logic rst,
  input  logic update,
  output logic tick
);

  logic u1;
  logic u2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      u1 <= 1'b0;
      u2 <= 1'b0;
    end else begin
      u1 <= update;
      u2 <= u1;
    end
  end

  assign tick = u1 & ~u2;

endmodule

// File: rtl/collision_monitor.sv
// Player/obstacle overlap accumulator and game-state FSM (lives, invulnerability, score).
// Optional anti-graze threshold and screen-region gate: define COLLISION_THRESHOLD_EN.
module collision_monitor
  import runner_pkg::*;
#(
  parameter int unsigned            LIVES_INIT    = 3,
  parameter int unsigned            INVULN_FRAMES = 30,
  parameter logic [BLOCK_LINES-1:0] BLOCK_MASK    = 16'h0007
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [9:0]             xCount,
  input  logic [9:0]             yCount,
  input  logic [BLOCK_LINES-1:0] blocks,
  input  logic                   player,
  input  logic                   update,
  input  logic                   start,
  output logic [1:0]             state,
  output logic [1:0]             lives,
  output logic [15:0]            score,
  output logic                   hit_flash,
  output logic [BLOCK_LINES-1:0] collide_mask
);

  localparam logic [1:0] LIVES_LD  = 2'(LIVES_INIT);
  localparam logic [5:0] INVULN_LD = 6'(INVULN_FRAMES);

  logic                   tick;
  logic [BLOCK_LINES-1:0] term;
  logic [BLOCK_LINES-1:0] accMask;
  logic [BLOCK_LINES-1:0] frameMask;
  logic                   hitNow;

  state_t      stateQ, stateD;
  logic [1:0]  livesQ, livesD;
  logic [15:0] scoreQ, scoreD;
  logic [15:0] scoreInc;
  logic [5:0]  invulnQ, invulnD;
  logic        armedQ, armedD;
  logic        hitFlashQ;

  frame_tick_detect uTick (
    .clk    (clk),
    .rst    (rst),
    .update (update),
    .tick   (tick)
  );

`ifdef COLLISION_THRESHOLD_EN
  logic        inRegion;
  logic [11:0] pixCount;
  logic [11:0] frameCount;

  assign inRegion   = (xCount < 10'(SCREEN_W)) && (yCount < 10'(SCREEN_H));
  assign term       = {BLOCK_LINES{player & inRegion}} & blocks & BLOCK_MASK;
  // Count saturates so a long graze cannot wrap back under the threshold.
  assign frameCount = (pixCount == '1) ? pixCount : pixCount + {11'd0, |term};
  assign hitNow     = (|frameMask) && (frameCount >= 12'd16);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixCount <= '0;
    end else if (tick) begin
      pixCount <= {11'd0, |term};
    end else begin
      pixCount <= frameCount;
    end
  end
`else
  logic unusedPos;

  assign unusedPos = ^{xCount, yCount};
  assign term      = {BLOCK_LINES{player}} & blocks & BLOCK_MASK;
  assign hitNow    = |frameMask;
`endif

  assign frameMask = accMask | term;

  // The tick-cycle pixel is reported with the closing frame but also seeds the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accMask      <= '0;
      collide_mask <= '0;
    end else if (tick) begin
      accMask      <= term;
      collide_mask <= frameMask;
    end else begin
      accMask      <= frameMask;
    end
  end

  assign scoreInc = (scoreQ == '1) ? scoreQ : scoreQ + 16'd1;

  always_comb begin
    stateD  = stateQ;
    livesD  = livesQ;
    scoreD  = scoreQ;
    invulnD = invulnQ;
    armedD  = armedQ;
    case (stateQ)
      ST_IDLE: begin
        scoreD = '0;
        livesD = LIVES_LD;
        if (tick && start) stateD = ST_PLAY;
      end
      ST_PLAY: begin
        if (tick) begin
          if (hitNow) begin
            if (livesQ <= 2'd1) begin
              stateD = ST_OVER;
              livesD = '0;
              armedD = 1'b0;
            end else begin
              stateD  = ST_HIT;
              livesD  = livesQ - 2'd1;
              invulnD = INVULN_LD;
            end
          end else begin
            scoreD = scoreInc;
          end
        end
      end
      ST_HIT: begin
        if (tick) begin
          scoreD = scoreInc;
          if (invulnQ <= 6'd1) begin
            stateD  = ST_PLAY;
            invulnD = '0;
          end else begin
            invulnD = invulnQ - 6'd1;
          end
        end
      end
      ST_OVER: begin
        // Restart needs start seen low at one tick, then high at a later one.
        if (tick) begin
          if (!start) begin
            armedD = 1'b1;
          end else if (armedQ) begin
            stateD = ST_IDLE;
            scoreD = '0;
            livesD = LIVES_LD;
            armedD = 1'b0;
          end
        end
      end
      default: stateD = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ    <= ST_IDLE;
      livesQ    <= LIVES_LD;
      scoreQ    <= '0;
      invulnQ   <= '0;
      armedQ    <= 1'b0;
      hitFlashQ <= 1'b0;
    end else begin
      stateQ    <= stateD;
      livesQ    <= livesD;
      scoreQ    <= scoreD;
      invulnQ   <= invulnD;
      armedQ    <= armedD;
      hitFlashQ <= (stateD == ST_HIT);
    end
  end

  assign state     = stateQ;
  assign lives     = livesQ;
  assign score     = scoreQ;
  assign hit_flash = hitFlashQ;

endmodule

// File: tb/tb_collision_monitor.sv
// Directed self-checking bench for collision_monitor (default or COLLISION_THRESHOLD_EN build).
module tb_collision_monitor;

  logic        clk;
  logic        rst;
  logic [9:0]  xCount;
  logic [9:0]  yCount;
  logic [15:0] blocks;
  logic        player;
  logic        update;
  logic        start;
  logic [1:0]  state;
  logic [1:0]  lives;
  logic [15:0] score;
  logic        hit_flash;
  logic [15:0] collide_mask;

  int unsigned nCompared;
  int unsigned nMismatched;

`ifdef COLLISION_THRESHOLD_EN
  localparam int unsigned HIT_PIX = 16;
`else
  localparam int unsigned HIT_PIX = 1;
`endif

  collision_monitor #(
    .LIVES_INIT    (3),
    .INVULN_FRAMES (30),
    .BLOCK_MASK    (16'h0007)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .xCount       (xCount),
    .yCount       (yCount),
    .blocks       (blocks),
    .player       (player),
    .update       (update),
    .start        (start),
    .state        (state),
    .lives        (lives),
    .score        (score),
    .hit_flash    (hit_flash),
    .collide_mask (collide_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive n overlapping pixels of the given obstacle lines, then clear the lines.
  task automatic pixels(input logic [15:0] blk, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      player = 1'b1;
      blocks = blk;
      step();
    end
    player = 1'b0;
    blocks = '0;
  endtask

  // Raise update; the FSM acts at the second edge. Hold extra cycles, then let the detector settle.
  task automatic frame(input int unsigned hold);
    update = 1'b1;
    step();
    step();
    for (int unsigned i = 0; i < hold; i++) step();
    update = 1'b0;
    step();
    step();
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    rst    = 1'b1;
    xCount = 10'd100;
    yCount = 10'd100;
    blocks = '0;
    player = 1'b0;
    update = 1'b0;
    start  = 1'b0;
    step();
    step();

    chk("rst_state", 32'(state), 32'd0);
    chk("rst_lives", 32'(lives), 32'd3);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_flash", 32'(hit_flash), 32'd0);
    chk("rst_mask", 32'(collide_mask), 32'd0);
    rst = 1'b0;
    step();

    start = 1'b1;
    frame(0);
    chk("start_state", 32'(state), 32'd1);
    chk("start_lives", 32'(lives), 32'd3);
    chk("start_score", 32'(score), 32'd0);
    start = 1'b0;

    for (int i = 0; i < 4; i++) frame(0);
    frame(6);
    chk("play5_score", 32'(score), 32'd5);
    chk("play5_mask", 32'(collide_mask), 32'd0);
    chk("play5_state", 32'(state), 32'd1);

    pixels(16'h0002, HIT_PIX);
    frame(0);
    chk("hit1_state", 32'(state), 32'd2);
    chk("hit1_lives", 32'(lives), 32'd2);
    chk("hit1_mask", 32'(collide_mask), 32'h0002);
    chk("hit1_flash", 32'(hit_flash), 32'd1);
    chk("hit1_score", 32'(score), 32'd5);

    for (int i = 0; i < 29; i++) begin
      pixels(16'h0001, HIT_PIX);
      frame(0);
    end
    chk("hit29_state", 32'(state), 32'd2);
    pixels(16'h0001, HIT_PIX);
    frame(0);
    chk("hit30_state", 32'(state), 32'd1);
    chk("hit30_lives", 32'(lives), 32'd2);
    chk("hit30_score", 32'(score), 32'd35);
    chk("hit30_flash", 32'(hit_flash), 32'd0);

    pixels(16'h0004, HIT_PIX);
    frame(0);
    chk("hit2_state", 32'(state), 32'd2);
    chk("hit2_lives", 32'(lives), 32'd1);
    chk("hit2_mask", 32'(collide_mask), 32'h0004);

    for (int i = 0; i < 30; i++) frame(0);
    chk("rec2_state", 32'(state), 32'd1);
    chk("rec2_score", 32'(score), 32'd65);

    pixels(16'h0003, HIT_PIX);
    frame(0);
    chk("over_state", 32'(state), 32'd3);
    chk("over_lives", 32'(lives), 32'd0);
    chk("over_score", 32'(score), 32'd65);
    chk("over_mask", 32'(collide_mask), 32'h0003);

    start = 1'b1;
    for (int i = 0; i < 3; i++) frame(0);
    chk("over_held", 32'(state), 32'd3);
    chk("over_frozen", 32'(score), 32'd65);
    start = 1'b0;
    frame(0);
    chk("over_low", 32'(state), 32'd3);
    start = 1'b1;
    frame(0);
    chk("restart_state", 32'(state), 32'd0);
    chk("restart_lives", 32'(lives), 32'd3);
    chk("restart_score", 32'(score), 32'd0);

    frame(0);
    chk("replay_state", 32'(state), 32'd1);
    start = 1'b0;
    pixels(16'h0008, HIT_PIX);
    frame(0);
    chk("masked_state", 32'(state), 32'd1);
    chk("masked_mask", 32'(collide_mask), 32'd0);
    chk("masked_score", 32'(score), 32'd1);

`ifdef COLLISION_THRESHOLD_EN
    pixels(16'h0002, 15);
    frame(0);
    chk("graze15_state", 32'(state), 32'd1);
    chk("graze15_mask", 32'(collide_mask), 32'h0002);
    chk("graze15_score", 32'(score), 32'd2);
    xCount = 10'd700;
    pixels(16'h0002, 20);
    xCount = 10'd100;
    frame(0);
    chk("offscreen_state", 32'(state), 32'd1);
    chk("offscreen_mask", 32'(collide_mask), 32'd0);
    pixels(16'h0002, 16);
    frame(0);
    chk("graze16_state", 32'(state), 32'd2);
`else
    pixels(16'h0002, 1);
    frame(0);
    chk("hit3_state", 32'(state), 32'd2);
`endif
    chk("hit3_lives", 32'(lives), 32'd2);

    step();
    rst = 1'b1;
    #1;
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_lives", 32'(lives), 32'd3);
    chk("midrst_flash", 32'(hit_flash), 32'd0);
    chk("midrst_score", 32'(score), 32'd0);
    step();
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
